// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command controller: ASCII command bytes and FSM encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RUN_U  = 8'h52;
    localparam logic [7:0] CMD_RUN_L  = 8'h72;
    localparam logic [7:0] CMD_CLR_U  = 8'h43;
    localparam logic [7:0] CMD_CLR_L  = 8'h63;
    localparam logic [7:0] CMD_MODE_U = 8'h4D;
    localparam logic [7:0] CMD_MODE_L = 8'h6D;
    localparam logic [7:0] CMD_SR04_U = 8'h55;
    localparam logic [7:0] CMD_SR04_L = 8'h75;
    localparam logic [7:0] CMD_DHT_U  = 8'h54;
    localparam logic [7:0] CMD_DHT_L  = 8'h74;
    localparam logic [7:0] CHR_CR     = 8'h0D;
    localparam logic [7:0] CHR_LF     = 8'h0A;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/uart_cmd_ctrl_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only if a pop frees a slot that same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder/dispatcher: pulses for watch commands, req/ack handshakes for sensors.
// Optional byte echo on the transmitter is enabled with `define CMD_ECHO_EN.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       sw_run_stop,
    output logic       sw_clear,
    output logic       mode_toggle,
    output logic       sr04_req,
    input  logic       sr04_ack,
    output logic       dht_req,
    input  logic       dht_ack,
    output logic       cmd_err,
    output logic       ack_timeout,
    output logic       rx_ovf,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);
    localparam int CW = $clog2(ACK_TIMEOUT);

    state_t        state;
    logic [7:0]    cmd_reg;
    logic [CW-1:0] cnt;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty, pop, ack;

    assign pop = (state == IDLE) && !fifo_empty;
    // Only the sensor currently being served can complete the handshake.
    assign ack = sr04_req ? sr04_ack : dht_ack;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_done),
        .din   (rx_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (rx_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_reg     <= '0;
            cnt         <= '0;
            sw_run_stop <= 1'b0;
            sw_clear    <= 1'b0;
            mode_toggle <= 1'b0;
            sr04_req    <= 1'b0;
            dht_req     <= 1'b0;
            cmd_err     <= 1'b0;
            ack_timeout <= 1'b0;
`ifdef CMD_ECHO_EN
            tx_data     <= '0;
            tx_start    <= 1'b0;
`endif
        end else begin
            sw_run_stop <= 1'b0;
            sw_clear    <= 1'b0;
            mode_toggle <= 1'b0;
            cmd_err     <= 1'b0;
            ack_timeout <= 1'b0;
`ifdef CMD_ECHO_EN
            tx_start    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_reg <= fifo_dout;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
`ifdef CMD_ECHO_EN
                    if (!tx_busy) begin
                        tx_data  <= cmd_reg;
                        tx_start <= 1'b1;
                    end
`endif
                    state <= IDLE;
                    case (cmd_reg)
                        CMD_RUN_U,  CMD_RUN_L:  sw_run_stop <= 1'b1;
                        CMD_CLR_U,  CMD_CLR_L:  sw_clear    <= 1'b1;
                        CMD_MODE_U, CMD_MODE_L: mode_toggle <= 1'b1;
                        CMD_SR04_U, CMD_SR04_L: begin
                            sr04_req <= 1'b1;
                            cnt      <= '0;
                            state    <= WAIT_ACK;
                        end
                        CMD_DHT_U,  CMD_DHT_L: begin
                            dht_req <= 1'b1;
                            cnt     <= '0;
                            state   <= WAIT_ACK;
                        end
                        CHR_CR, CHR_LF: ;
                        default: cmd_err <= 1'b1;
                    endcase
                end
                WAIT_ACK: begin
                    if (ack) begin
                        sr04_req <= 1'b0;
                        dht_req  <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        sr04_req    <= 1'b0;
                        dht_req     <= 1'b0;
                        ack_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CMD_ECHO_EN
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data  = '0;
    assign tx_start = 1'b0;
`endif

endmodule
